// File: rtl/encoder8_3_stream_if.sv
// Stream bundle for the 8-to-3 priority encoder: upstream word handshake,
// downstream entry handshake and the running error count.
interface encoder8_3_stream_if #(
  parameter int ERR_W = 8
);
  logic             valid;
  logic [7:0]       in;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [2:0]       out;
  logic             zero_err;
  logic             multi_err;
  logic [ERR_W-1:0] err_count;

  modport slave (
    input  valid, in, out_ready,
    output in_ready, out_valid, out, zero_err, multi_err, err_count
  );

  modport master (
    output valid, in, out_ready,
    input  in_ready, out_valid, out, zero_err, multi_err, err_count
  );
endinterface

// File: rtl/encoder8_3_stream.sv
// 8-to-3 priority encoder feeding a 2-entry output FIFO, with zero/multi-hot
// flags per entry and a saturating count of flagged words.
module encoder8_3_stream #(
  parameter int PRI_HIGH = 1,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  encoder8_3_stream_if.slave  bus
);

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             zero_err;
    logic             multi_err;
  } entry_t;

  function automatic logic [IDX_W-1:0] win_idx(input logic [DATA_W-1:0] w);
    logic [IDX_W-1:0] r;
    r = '0;
    if (PRI_HIGH != 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (w[i]) r = IDX_W'(i);
      end
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (w[i]) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more were set.
  function automatic logic is_multi(input logic [DATA_W-1:0] w);
    return (w & (w - DATA_W'(1))) != '0;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  occ_e             state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  entry_t           mem_q [2];
  entry_t           mem_d [2];

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  entry_t enc;
  entry_t head;

  // Encode stage: purely combinational, captured straight into the FIFO slot
  always_comb begin
    enc.idx       = win_idx(bus.in);
    enc.zero_err  = (bus.in == '0);
    enc.multi_err = is_multi(bus.in);
  end

  assign push = bus.valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    err_cnt_d = err_cnt_q;
    if (push && (enc.zero_err || enc.multi_err)) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Storage stage: payload only, validity is tracked by the occupancy state
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = enc;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output stage: payload is masked while empty so reset shows all-zero outputs
  assign head          = mem_q[rd_ptr_q];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_valid ? head.idx       : '0;
  assign bus.zero_err  = out_valid ? head.zero_err  : 1'b0;
  assign bus.multi_err = out_valid ? head.multi_err : 1'b0;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_encoder8_3_stream.sv
// Scoreboard bench: three encoder instances (high priority, low priority,
// 2-bit counter) share one stimulus stream and are checked against a model.
module tb_encoder8_3_stream;

  typedef struct {
    logic [2:0] hi;
    logic [2:0] lo;
    logic       z;
    logic       m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_in    = 8'h00;
  logic       drv_ordy  = 1'b0;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];
  int   cnt_hi  = 0;
  int   cnt_sat = 0;
  logic last_acc;

  always #5 clk = ~clk;

  encoder8_3_stream_if #(.ERR_W(8)) if_hi ();
  encoder8_3_stream_if #(.ERR_W(8)) if_lo ();
  encoder8_3_stream_if #(.ERR_W(2)) if_sat ();

  assign if_hi.valid      = drv_valid;
  assign if_hi.in         = drv_in;
  assign if_hi.out_ready  = drv_ordy;
  assign if_lo.valid      = drv_valid;
  assign if_lo.in         = drv_in;
  assign if_lo.out_ready  = drv_ordy;
  assign if_sat.valid     = drv_valid;
  assign if_sat.in        = drv_in;
  assign if_sat.out_ready = drv_ordy;

  encoder8_3_stream #(.PRI_HIGH(1), .ERR_W(8)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));
  encoder8_3_stream #(.PRI_HIGH(0), .ERR_W(8)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));
  encoder8_3_stream #(.PRI_HIGH(1), .ERR_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if_sat));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] w);
    exp_t e;
    int v, k;
    e.z  = (w == 8'h00);
    e.m  = ($countones(w) >= 2);
    e.hi = 3'd0;
    e.lo = 3'd0;
    if (w != 8'h00) begin
      v = int'(w); k = 0;
      while (v > 1) begin v = v / 2; k++; end
      e.hi = 3'(k);
      v = int'(w); k = 0;
      while (v % 2 == 0) begin v = v / 2; k++; end
      e.lo = 3'(k);
    end
    return e;
  endfunction

  // Drives inputs just after an edge; the model entry enters the queue just
  // before the edge that accepts it.
  task automatic drive_body(input logic v, input logic [7:0] w, input logic ordy);
    logic acc;
    drv_valid = v;
    drv_in    = w;
    drv_ordy  = ordy;
    acc       = v && (q.size() != 2);
    last_acc  = acc;
    #8;
    if (acc) begin
      exp_t e;
      e = model(w);
      q.push_back(e);
      if (e.z || e.m) begin
        if (cnt_hi < 255) cnt_hi++;
        if (cnt_sat < 3)  cnt_sat++;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] w, input logic ordy);
    @(posedge clk);
    #1;
    drive_body(v, w, ordy);
  endtask

  // Monitor: compares the DUTs to the state the model holds after the last edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("hi_out_valid", if_hi.out_valid, q.size() != 0);
      chk("hi_in_ready",  if_hi.in_ready,  q.size() != 2);
      chk("lo_out_valid", if_lo.out_valid, q.size() != 0);
      chk("sat_in_ready", if_sat.in_ready, q.size() != 2);
      chk("hi_err_count",  if_hi.err_count,  cnt_hi);
      chk("lo_err_count",  if_lo.err_count,  cnt_hi);
      chk("sat_err_count", if_sat.err_count, cnt_sat);
      if (q.size() != 0) begin
        chk("hi_out",       if_hi.out,       q[0].hi);
        chk("hi_zero_err",  if_hi.zero_err,  q[0].z);
        chk("hi_multi_err", if_hi.multi_err, q[0].m);
        chk("lo_out",       if_lo.out,       q[0].lo);
        chk("lo_multi_err", if_lo.multi_err, q[0].m);
        chk("sat_out",      if_sat.out,      q[0].hi);
        chk("sat_zero_err", if_sat.zero_err, q[0].z);
        if (drv_ordy) void'(q.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, if_hi.out_valid, 1'b0);
    chk({tag, "_in_ready"},  if_hi.in_ready,  1'b1);
    chk({tag, "_out"},       if_hi.out,       3'd0);
    chk({tag, "_zero_err"},  if_hi.zero_err,  1'b0);
    chk({tag, "_multi_err"}, if_hi.multi_err, 1'b0);
    chk({tag, "_err_count"}, if_hi.err_count, 8'd0);
    chk({tag, "_sat_err"},   if_sat.err_count, 2'd0);
    chk({tag, "_lo_valid"},  if_lo.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    logic [7:0] w;

    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First edge after release accepts 0010_0100
    drive_body(1'b1, 8'b0010_0100, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(1 << i), 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: third word waits until a slot frees
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h08, 1'b0);
    cycle(1'b1, 8'h40, 1'b0);
    chk("bp_third_rejected", last_acc, 1'b0);
    cycle(1'b1, 8'h40, 1'b0);
    budget = 0;
    do begin
      cycle(1'b1, 8'h40, 1'b1);
      budget++;
    end while (!last_acc && budget < 10);
    chk("bp_accept_budget", budget < 10, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       w = 8'h00;
        1:       w = 8'(1 << $urandom_range(0, 7));
        default: w = 8'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Fill up, then reset between edges and confirm nothing stale survives
    cycle(1'b1, 8'h81, 1'b0);
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("full_before_reset", if_hi.in_ready, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    q.delete();
    cnt_hi  = 0;
    cnt_sat = 0;
    drv_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive_body(1'b1, 8'h04, 1'b1);
    for (int n = 0; n < 60; n++) begin
      cycle($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b1);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder8_3_stream.md
ENCODER8_3_STREAM -- requirements
Module: encoder8_3_stream

Interface
REQ-001 Parameter PRI_HIGH, default 1, selects the priority winner: 1 = highest set index wins, 0 = lowest set index wins.
REQ-002 Parameter ERR_W, default 8, is the width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 valid  input  1  upstream word valid.
REQ-006 in  input  8  line word to encode.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_ready  input  1  downstream accepts the head entry.
REQ-009 out_valid  output  1  head entry present on out/zero_err/multi_err.
REQ-010 out  output  3  encoded index of the head entry.
REQ-011 zero_err  output  1  head entry came from in == 8'h00.
REQ-012 multi_err  output  1  head entry came from an input with more than one bit set.
REQ-013 err_count  output  ERR_W  saturating count of accepted words with zero_err or multi_err.

Function
REQ-014 Accept: a word is taken on a clock edge where valid && in_ready; in and valid are ignored otherwise.
REQ-015 Encode: for an accepted word, out = index of the winning set bit per PRI_HIGH; in == 0 gives out = 3'd0 with zero_err = 1.
REQ-016 Flags: multi_err = 1 if popcount(in) >= 2; zero_err and multi_err are never both 1.
REQ-017 Buffer: encoded entries {out, zero_err, multi_err} enter a 2-entry FIFO and leave in acceptance order.
REQ-018 Latency: an entry accepted at edge N into an empty FIFO drives out_valid = 1 from after edge N; there is no combinational path from in to out.
REQ-019 Occupancy: states EMPTY(0), ONE(1), FULL(2); out_valid = (occupancy != 0); in_ready = (occupancy != 2), derived from registered state only.
REQ-020 Pop: the head is removed on an edge where out_valid && out_ready.
REQ-021 Transitions:
  - EMPTY + push -> ONE.
  - ONE + push, no pop -> FULL.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE, with the new entry becoming head.
  - FULL + pop -> ONE.
  - FULL never pushes.
REQ-022 Stability: while out_valid && !out_ready, out, zero_err and multi_err hold constant.
REQ-023 Counter: err_count increments by 1 on each accepted word with zero_err or multi_err; it holds at 2^ERR_W-1 (no wrap); counting happens at acceptance, not at pop.
REQ-024 Pointers: the read/write index wrap-around modulo 2 shall not corrupt order under any push/pop sequence.

Reset
REQ-025 When rst is asserted, the following are forced immediately, independent of clk:
  - occupancy = 0, so out_valid = 0 and in_ready = 1.
  - out = 3'd0, zero_err = 0, multi_err = 0.
  - err_count = 0.
REQ-026 Reset mid-operation discards all buffered entries; no entry accepted before reset appears after it.
REQ-027 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-028 Reset, then valid=1 in=8'b0010_0100 out_ready=1 with PRI_HIGH=1 -> one cycle later out_valid=1, out=3'd5, zero_err=0, multi_err=1, err_count=1.
REQ-029 Same input with PRI_HIGH=0 -> out=3'd2, multi_err=1.
REQ-030 Sweep in=8'h01..8'h80 (one-hot), out_ready=1, streamed every cycle -> out=0..7 in order, at one per cycle, with no flags set and err_count=0.
REQ-031 Backpressure: out_ready=0, offer 8'h02, 8'h08, 8'h40 on consecutive cycles -> first two accepted, in_ready=0 on the third cycle, out holds 3'd1; then raise out_ready -> outputs 1, 3, then 6 once accepted, with no loss or duplication.
REQ-032 Saturation with ERR_W=2: offer 5 words of in=8'h00 -> err_count reads 1, 2, 3, 3, 3, and each entry has zero_err=1, out=0.
REQ-033 Async reset while FULL: assert rst between clock edges -> out_valid=0, in_ready=1, err_count=0 without waiting for an edge; after release, no stale entries are emitted.
